irq_pend_ctrl: RTL

- Upstream stage of the 4:2 priority encoder (Encpri).
- Synchronises four request lines, edge-detects them and latches sticky pending bits.
- Drives the masked pending vector into the encoder's 4-bit input, raises an interrupt and runs a valid/ack handshake.
- The consumer returns the encoder's 2-bit output as the acknowledged index, which clears that pending bit.

---
 rtl/irq_pend_if.sv | 33 +++
 rtl/irq_pend_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/irq_pend_if.sv
// Handshake bundle between the request pending controller and its consumer.
//   req      : asynchronous request lines (rising edge = event)
//   mask     : level mask hiding lines from pend/irq
//   ack      : one-cycle acknowledge pulse from the consumer
//   ack_idx  : index being acknowledged (encoder output)
//   ovr_clr  : write-1-to-clear pulses for the overrun flags
//   pend     : masked pending vector feeding the encoder input
//   irq      : interrupt request
//   ovr      : sticky overrun flags
//   ack_err  : one-cycle pulse on an ack of a non-pending line
interface irq_pend_if;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_idx;
    logic [3:0] ovr_clr;
    logic [3:0] pend;
    logic       irq;
    logic [3:0] ovr;
    logic       ack_err;

    // Consumer side: drives requests, mask and acknowledges.
    modport master (
        output req, mask, ack, ack_idx, ovr_clr,
        input  pend, irq, ovr, ack_err
    );

    // Controller side.
    modport slave (
        input  req, mask, ack, ack_idx, ovr_clr,
        output pend, irq, ovr, ack_err
    );
endinterface

// File: rtl/irq_pend_ctrl.sv
// Request pending controller in front of the 4:2 priority encoder.
// Synchronises and edge-detects four request lines, keeps sticky pending
// bits, presents the masked pending vector and runs an irq/ack handshake
// with a guaranteed irq-low gap after every acknowledge.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : irq_pend_if.slave (req, mask, ack, ack_idx, ovr_clr in;
//           pend, irq, ovr, ack_err out, all registered)
module irq_pend_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    irq_pend_if.slave    bus
);
    localparam int unsigned NLINES = 4;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t                               state_q;
    logic [SYNC_STAGES-1:0][NLINES-1:0]   sync_q;
    logic [NLINES-1:0]                    hist_q;
    logic [NLINES-1:0]                    pending_q;
    logic [NLINES-1:0]                    pend_q;
    logic [NLINES-1:0]                    ovr_q;
    logic                                 irq_q;
    logic                                 ack_err_q;
    logic [CNT_W-1:0]                     gap_cnt_q;

    logic [NLINES-1:0] sync_out;
    logic [NLINES-1:0] evt;
    logic [NLINES-1:0] clr;
    logic [NLINES-1:0] pending_nxt;
    logic [NLINES-1:0] ovr_nxt;
    logic              ack_ok;
    logic              bad_ack;

    // Event detection, ack decode and next pending/overrun state.
    always_comb begin
        sync_out    = sync_q[SYNC_STAGES-1];
        evt         = sync_out & ~hist_q;
        ack_ok      = (state_q == ST_ASSERT) && bus.ack;
        clr         = '0;
        bad_ack     = 1'b0;
        if (ack_ok) begin
            clr[bus.ack_idx] = pending_q[bus.ack_idx];
            bad_ack          = !pending_q[bus.ack_idx];
        end
        // An event on a line being cleared re-sets it and is not an overrun.
        pending_nxt = (pending_q & ~clr) | evt;
        ovr_nxt     = (ovr_q & ~bus.ovr_clr) | (evt & pending_q & ~clr);
    end

    // Synchroniser, edge history, pending bits and masked output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            hist_q    <= '0;
            pending_q <= '0;
            pend_q    <= '0;
            ovr_q     <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.req};
            hist_q    <= sync_out;
            pending_q <= pending_nxt;
            pend_q    <= pending_nxt & ~bus.mask;
            ovr_q     <= ovr_nxt;
        end
    end

    // Handshake FSM with registered irq/ack_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            irq_q     <= 1'b0;
            ack_err_q <= 1'b0;
            gap_cnt_q <= '0;
        end else begin
            ack_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pend_q != '0) begin
                        state_q <= ST_ASSERT;
                        irq_q   <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (bus.ack) begin
                        state_q   <= ST_GAP;
                        irq_q     <= 1'b0;
                        gap_cnt_q <= CNT_W'(GAP_CYCLES);
                        ack_err_q <= bad_ack;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q <= CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pend    = pend_q;
    assign bus.irq     = irq_q;
    assign bus.ovr     = ovr_q;
    assign bus.ack_err = ack_err_q;

endmodule
